// File: rtl/delay_timer_arbiter_if.sv
// Request/grant bundle between the requesters and the shared delay timer.
// master = requester side, slave = timer side.
interface delay_timer_arbiter_if #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned DUR_W = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DUR_W-1:0] dur;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       done;
    logic                   busy;
    logic [DUR_W-1:0]       remaining;

    modport master (
        output req, dur,
        input  grant, done, busy, remaining
    );

    modport slave (
        input  req, dur,
        output grant, done, busy, remaining
    );
endinterface

// File: rtl/delay_timer_arbiter.sv
// One shared 0.1 s tick timer, handed round-robin to N_REQ requesters.
// Each grant times dur ticks, then pulses done for one cycle.
module delay_timer_arbiter #(
    parameter int unsigned TICK_CYCLES = 10_000_000,
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned DUR_W       = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    delay_timer_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PreW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic [IdxW-1:0]   win_q, win_d;
    logic [PreW-1:0]   pre_q, pre_d;
    logic [DUR_W-1:0]  rem_q, rem_d;

    logic              pick_valid;
    logic [IdxW-1:0]   pick_idx;
    logic [DUR_W-1:0]  pick_dur;
    logic [31:0]       cand;
    logic [IdxW-1:0]   win_next;
    logic [N_REQ-1:0]  win_oh;
    logic              tick_last;
    logic              win_req;

    // Round-robin scan starting at ptr_q, wrapping past N_REQ-1.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = (32'(ptr_q) + i) % N_REQ;
            if (!pick_valid && bus.req[cand[IdxW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IdxW-1:0];
            end
        end
    end

    assign pick_dur  = bus.dur[32'(pick_idx) * DUR_W +: DUR_W];
    assign win_next  = (32'(win_q) == N_REQ - 1) ? '0 : win_q + 1'b1;
    assign tick_last = (pre_q == PreLast);
    assign win_req   = bus.req[win_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) state_d = (pick_dur != '0) ? StRun : StDone;
            end
            StRun: begin
                // Cancel wins over a coincident final tick.
                if (!win_req) state_d = StIdle;
                else if (tick_last && rem_q == DUR_W'(1)) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            win_q <= '0;
            pre_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            win_q <= win_d;
            pre_q <= pre_d;
            rem_q <= rem_d;
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        win_d = win_q;
        pre_d = pre_q;
        rem_d = rem_q;
        unique case (state_q)
            StIdle: begin
                pre_d = '0;
                rem_d = '0;
                if (pick_valid) begin
                    win_d = pick_idx;
                    rem_d = pick_dur;
                end
            end
            StRun: begin
                if (!win_req) begin
                    ptr_d = win_next;
                    pre_d = '0;
                    rem_d = '0;
                end else if (tick_last) begin
                    pre_d = '0;
                    if (rem_q != '0) rem_d = rem_q - 1'b1;
                end else begin
                    pre_d = pre_q + 1'b1;
                end
            end
            StDone: begin
                ptr_d = win_next;
                rem_d = '0;
            end
            default: begin
                rem_d = '0;
            end
        endcase
    end

    always_comb begin
        win_oh        = '0;
        win_oh[win_q] = 1'b1;
        bus.grant     = (state_q != StIdle) ? win_oh : '0;
        bus.done      = (state_q == StDone) ? win_oh : '0;
        bus.busy      = (state_q != StIdle);
        bus.remaining = rem_q;
    end
endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Scoreboard bench: each scenario pushes per-cycle expected outputs derived
// from grant time and duration; a negedge monitor pops and compares them.
module tb_delay_timer_arbiter;
    localparam int unsigned TICK = 4;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    delay_timer_arbiter_if #(.N_REQ(NREQ), .DUR_W(DW)) bus ();

    delay_timer_arbiter #(
        .TICK_CYCLES(TICK),
        .N_REQ      (NREQ),
        .DUR_W      (DW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        logic [3:0] g;
        logic [3:0] d;
        logic       b;
        logic [7:0] r;
    } exp_t;

    exp_t exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    task automatic push_exp(input int c, input logic [3:0] g, input logic [3:0] d,
                            input logic b, input logic [7:0] r);
        exp_t e;
        e.cyc = c;
        e.g   = g;
        e.d   = d;
        e.b   = b;
        e.r   = r;
        exp_q.push_back(e);
    endtask

    // Full grant window G..G+dur*TICK, then one idle cycle.
    task automatic expect_grant(input int g0, input int idx, input int dur);
        logic [3:0] oh;
        int         last;
        oh   = 4'b0001 << idx;
        last = dur * int'(TICK);
        for (int k = 0; k <= last; k++) begin
            if (k == last) push_exp(g0 + k, oh, oh, 1'b1, 8'd0);
            else push_exp(g0 + k, oh, 4'b0000, 1'b1, 8'(dur - k / int'(TICK)));
        end
        push_exp(g0 + last + 1, 4'b0000, 4'b0000, 1'b0, 8'd0);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    check_eq($sformatf("stale@%0d", e.cyc), 32'(cyc), 32'(e.cyc));
                end else begin
                    check_eq($sformatf("grant@%0d", cyc), 32'(bus.grant), 32'(e.g));
                    check_eq($sformatf("done@%0d", cyc), 32'(bus.done), 32'(e.d));
                    check_eq($sformatf("busy@%0d", cyc), 32'(bus.busy), 32'(e.b));
                    check_eq($sformatf("remaining@%0d", cyc), 32'(bus.remaining), 32'(e.r));
                end
            end
        end
    end

    initial begin
        int c;
        int g;
        bus.req = '0;
        bus.dur = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_grant", 32'(bus.grant), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_remaining", 32'(bus.remaining), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Round robin: all requesting, dur=1; grants 0,1,2,3,0 six cycles apart.
        c = cyc;
        bus.dur = {8'd1, 8'd1, 8'd1, 8'd1};
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) expect_grant(c + 1 + 6 * i, i % 4, 1);
        wait_until(c + 1 + 24 + 4);
        bus.req = '0;
        wait_until(c + 1 + 24 + 8);

        // Single request, dur=3 (ptr now 1, req0 still found by wrap).
        c = cyc;
        bus.dur = '0;
        bus.dur[7:0] = 8'd3;
        bus.req = 4'b0001;
        expect_grant(c + 1, 0, 3);
        wait_until(c + 1 + 12);
        bus.req = '0;
        wait_until(c + 16);

        // Zero duration on requester 2.
        c = cyc;
        bus.dur[23:16] = 8'd0;
        bus.req = 4'b0100;
        expect_grant(c + 1, 2, 0);
        wait_until(c + 1);
        bus.req = '0;
        wait_until(c + 5);

        // Reset mid-run with ptr=3; afterwards req=1010 must go to requester 1.
        c = cyc;
        bus.dur[7:0] = 8'd3;
        bus.req = 4'b0001;
        g = c + 1;
        for (int k = 0; k < 5; k++) push_exp(g + k, 4'b0001, 4'b0000, 1'b1, 8'(3 - k / 4));
        wait_until(g + 4);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_grant", 32'(bus.grant), 32'd0);
        check_eq("async_busy", 32'(bus.busy), 32'd0);
        check_eq("async_remaining", 32'(bus.remaining), 32'd0);
        check_eq("async_done", 32'(bus.done), 32'd0);
        bus.dur[15:8]  = 8'd2;
        bus.dur[31:24] = 8'd2;
        bus.req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        expect_grant(c + 1, 1, 2);
        wait_until(c + 1 + 8);
        bus.req = '0;
        wait_until(c + 13);

        // Cancel: req1 dur=5 dropped at G+6; pending req3 granted at G+8.
        c = cyc;
        bus.dur[15:8]  = 8'd5;
        bus.dur[31:24] = 8'd1;
        bus.req = 4'b0010;
        g = c + 1;
        for (int k = 0; k <= 6; k++) push_exp(g + k, 4'b0010, 4'b0000, 1'b1, 8'(5 - k / 4));
        push_exp(g + 7, 4'b0000, 4'b0000, 1'b0, 8'd0);
        expect_grant(g + 8, 3, 1);
        wait_until(g + 1);
        bus.req = 4'b1010;
        wait_until(g + 6);
        bus.req = 4'b1000;
        wait_until(g + 8 + 4);
        bus.req = '0;
        wait_until(g + 16);

        // dur change after grant is ignored.
        c = cyc;
        bus.dur[7:0] = 8'd2;
        bus.req = 4'b0001;
        g = c + 1;
        expect_grant(g, 0, 2);
        wait_until(g + 1);
        bus.dur[7:0] = 8'd9;
        wait_until(g + 8);
        bus.req = '0;
        wait_until(g + 13);

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/delay_timer_arbiter.md
Name: delay_timer_arbiter

Overview:
- Shares one 0.1 s timebase/delay counter among N_REQ requesters (game-phase FSMs, LED blink, debounce holds).
- Round-robin arbitration grants one requester at a time, times its requested duration in 0.1 s ticks, then returns a one-cycle done pulse.
- Replaces per-consumer free-running timer instances.
- Sits between top-level control FSMs and the board clock domain.

Parameters:
- TICK_CYCLES, 10_000_000, clk cycles per 0.1 s tick (100 MHz board clock); overridden to small values in simulation.
- N_REQ, 4, number of requesters (2..8).
- DUR_W, 8, width of each duration field, in tick units.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request level; hold high until done or to keep waiting.
- dur  input  N_REQ*DUR_W  packed durations; requester i uses dur[i*DUR_W +: DUR_W]; sampled only at grant.
- grant  output  N_REQ  one-hot; high while requester owns the timer.
- done  output  N_REQ  one-hot one-cycle pulse at end of timing.
- busy  output  1  high whenever state != IDLE.
- remaining  output  DUR_W  whole ticks left for current grant; 0 in IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; grant=0; done=0; busy=0; remaining=0; prescaler=0.
  - RR pointer=0, so requester 0 has highest priority first.
  - Reset applied mid-RUN aborts silently; no done is issued.
- States:
  - IDLE: no grant. If any req is high, pick the first high req scanning from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...).
  - On that edge, latch the winner index and remaining=dur[winner], set grant[winner]=1, clear prescaler.
  - Next state is RUN if dur!=0, otherwise DONE.
  - RUN: prescaler counts 0..TICK_CYCLES-1 and wraps. At the terminal count, remaining decrements.
  - When the terminal count coincides with remaining==1, go to DONE (remaining becomes 0).
  - DONE: exactly one cycle. grant[winner] stays high, done[winner]=1. Next edge: IDLE, grant=0, done=0, ptr=(winner+1) mod N_REQ.
- Timing: if grant first rises in cycle G, done is high in cycle G + dur*TICK_CYCLES. grant is high for cycles G..G+dur*TICK_CYCLES inclusive.
- dur==0: grant and done are high together in cycle G only.
- Minimum one IDLE cycle between consecutive grants.
- Cancel: if req[winner] falls during RUN, the next edge goes to IDLE with grant=0, no done, remaining=0, ptr=(winner+1) mod N_REQ. A req drop during DONE is ignored; done still pulses.
- Requester holding req high after done stays eligible, but only after the other requesters in RR order.
- Changes to dur after grant are ignored. req changes of non-winners during RUN/DONE have no effect until IDLE.
- Arithmetic:
  - Prescaler width is $clog2(TICK_CYCLES), minimum 1 bit.
  - Terminal compare is against TICK_CYCLES-1 at that width, so there is no overflow for the default value.
  - remaining never underflows.

Test Plan (TICK_CYCLES=4, N_REQ=4, DUR_W=8):
- Single request: req=0001, dur0=3 from idle → grant=0001 from cycle G; remaining goes 3,2,1 at G+4, G+8; done=0001 exactly at G+12; grant low at G+13.
- Round robin: req=1111 held continuously, all dur=1 → grants in order 0,1,2,3,0; each done 4 cycles after its grant; exactly one IDLE cycle between grants.
- Zero duration: req=0100, dur2=0 → grant=0100 and done=0100 in the same single cycle; IDLE next cycle.
- Cancel: req=0010, dur1=5; drop req1 at G+6 → grant=0 at G+7, no done pulse, remaining=0; next pending req3 is granted at G+8.
- Reset mid-operation: rst_n low asynchronously at G+5 during dur=3 → grant/busy/remaining are 0 immediately (not at next edge). After release with req=1010, requester 1 is granted first (ptr=0).
- dur change after grant: change dur0 from 2 to 9 at G+1 → done still at G+8.
